// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants for the MIPS32 instruction fetch unit.
// Holds the default reset PC, the bubble word and the fetch stride.
package instruction_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES   = 32'd4;

endpackage

// File: rtl/instruction_fetch_unit_skid.sv
// One-entry holding register for a fetch that lands while decode stalls.
// Ports: clk_i/rst_ni, load_i/drain_i/flush_i controls, instr/pc4 in and out.
module instruction_fetch_unit_skid
  import instruction_fetch_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;

  // Flush beats load beats drain.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc4_d   = pc4_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS32 fetch front end: PC, 1-cycle IM interface, skid, IF/ID register.
// Ports: Clk/Rst_n, ID stall/redirect in, IM req/addr/rdata, IF_ID_* out.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        ID_stall,
  input  logic        ID_PCSrc,
  input  logic [31:0] ID_new_PC,
  output logic        IM_req,
  output logic [31:0] IM_addr,
  input  logic [31:0] IM_rdata,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_valid
);

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc4_q, pend_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic        redirect;
  logic        skid_valid, skid_load, skid_drain;
  logic [31:0] skid_instr, skid_pc4;

  // Branch operands are not ready while stalled.
  assign redirect = ID_PCSrc & ~ID_stall;
  assign pc_plus4 = pc_q + WORD_BYTES;

  // Stop issuing once the in-flight word has nowhere to go.
  assign IM_req  = ~redirect & ~skid_valid
                 & ~(ID_stall & pend_valid_q);
  assign IM_addr = {pc_q[31:2], 2'b00};

  assign skid_load  = ~redirect & ID_stall
                    & pend_valid_q & ~skid_valid;
  assign skid_drain = ~redirect & ~ID_stall & skid_valid;

  instruction_fetch_unit_skid u_skid (
    .clk_i   (Clk),
    .rst_ni  (Rst_n),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .flush_i (redirect),
    .instr_i (IM_rdata),
    .pc4_i   (pend_pc4_q),
    .valid_o (skid_valid),
    .instr_o (skid_instr),
    .pc4_o   (skid_pc4)
  );

  always_comb begin
    pc_d         = pc_q;
    pend_valid_d = IM_req;
    pend_pc4_d   = pend_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;

    if (redirect) begin
      pc_d = ID_new_PC & ~32'd3;
    end else if (IM_req) begin
      pc_d       = pc_plus4;
      pend_pc4_d = pc_plus4;
    end

    if (redirect) begin
      ifid_instr_d = NOP_WORD;
      ifid_pc4_d   = '0;
      ifid_valid_d = 1'b0;
    end else if (ID_stall) begin
      ifid_instr_d = ifid_instr_q;
    end else if (skid_valid) begin
      ifid_instr_d = skid_instr;
      ifid_pc4_d   = skid_pc4;
      ifid_valid_d = 1'b1;
    end else if (pend_valid_q) begin
      ifid_instr_d = IM_rdata;
      ifid_pc4_d   = pend_pc4_q;
      ifid_valid_d = 1'b1;
    end else begin
      ifid_instr_d = NOP_WORD;
      ifid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc4_q   <= '0;
      ifid_instr_q <= NOP_WORD;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc4_q   <= pend_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign IF_ID_Instruction = ifid_instr_q;
  assign IF_ID_PC4         = ifid_pc4_q;
  assign IF_ID_valid       = ifid_valid_q;

endmodule
